// File: rtl/top_level_system.sv
// Dot-product engine: A/B vectors live in local memories, start MACs elements 0..VECTOR_WIDTH-1 into an 8-slot result ring.
// Latency: start sampled at edge N, result stored at edge N+6, system_done high for the one cycle after that edge.
// Backpressure: none; writes and starts are ignored while busy, result readout is combinational and always available.
module top_level_system #(
   parameter int DATA_WIDTH      = 8,
   parameter int VECTOR_WIDTH    = 4,
   parameter int DEPTH           = 32,
   parameter int ADDR_WIDTH      = 5,
   parameter int RESULT_WIDTH    = 2*DATA_WIDTH + $clog2(VECTOR_WIDTH),
   parameter int MEM3_ADDR_WIDTH = 4,
   parameter int MEM3_SIZE       = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       system_start,
   output logic                       system_busy,
   output logic                       system_done,
   input  logic                       write_en,
   input  logic [ADDR_WIDTH-1:0]      write_addr,
   input  logic [DATA_WIDTH-1:0]      data_a,
   input  logic [DATA_WIDTH-1:0]      data_b,
   input  logic                       read_en,
   input  logic [MEM3_ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0]      result_out,
   output logic [2:0]                 processing_stage,
   output logic [2:0]                 vector_count,
   output logic [2:0]                 result_count
);

   localparam int RES_ENTRIES = MEM3_SIZE / DATA_WIDTH;
   localparam int RC_W        = $clog2(RES_ENTRIES);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_COMPUTE = 3'd2,
      ST_STORE   = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   state_t                  state_q;
   logic [RESULT_WIDTH-1:0] acc_q;
   logic [RESULT_WIDTH-1:0] acc_d;
   logic [2:0]              vc_q;
   logic [RC_W-1:0]         rc_q;
   logic                    busy_q;
   logic                    done_q;

   logic [DATA_WIDTH-1:0]   mem_a_q [DEPTH];
   logic [DATA_WIDTH-1:0]   mem_b_q [DEPTH];
   logic [DATA_WIDTH-1:0]   res_q   [RES_ENTRIES];

   // Readout is continuous, so the strobe carries no information for the datapath.
   logic read_en_unused;
   assign read_en_unused = read_en;

   // Next accumulator value: current element pair product added to the running sum.
   always_comb begin
      acc_d = acc_q + (RESULT_WIDTH'(mem_a_q[ADDR_WIDTH'(vc_q)]) *
                       RESULT_WIDTH'(mem_b_q[ADDR_WIDTH'(vc_q)]));
   end

   // Input memories accept host writes only while the engine is idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_a_q[i] <= '0;
            mem_b_q[i] <= '0;
         end
      end else if (write_en && (state_q == ST_IDLE)) begin
         mem_a_q[write_addr] <= data_a;
         mem_b_q[write_addr] <= data_b;
      end
   end

   // Control FSM with registered busy/done, accumulator, counters and result ring.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         vc_q    <= '0;
         rc_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < RES_ENTRIES; i++) begin
            res_q[i] <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (system_start) begin
                  state_q <= ST_LOAD;
                  busy_q  <= 1'b1;
               end
            end
            ST_LOAD: begin
               acc_q   <= '0;
               vc_q    <= '0;
               state_q <= ST_COMPUTE;
            end
            ST_COMPUTE: begin
               acc_q <= acc_d;
               vc_q  <= vc_q + 3'd1;
               if (vc_q == 3'(VECTOR_WIDTH - 1)) begin
                  state_q <= ST_STORE;
               end
            end
            ST_STORE: begin
               // Only the low byte is kept; the ring pointer wraps onto the oldest slot.
               res_q[rc_q] <= acc_q[DATA_WIDTH-1:0];
               rc_q        <= rc_q + 1'b1;
               done_q      <= 1'b1;
               state_q     <= ST_DONE;
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Combinational readout; addresses beyond the ring return zero.
   always_comb begin
      result_out = '0;
      if (read_addr < MEM3_ADDR_WIDTH'(RES_ENTRIES)) begin
         result_out = res_q[read_addr[RC_W-1:0]];
      end
   end

   assign system_busy      = busy_q;
   assign system_done      = done_q;
   assign processing_stage = state_q;
   assign vector_count     = vc_q;
   assign result_count     = 3'(rc_q);

endmodule

// File: tb/tb_top_level_system.sv
// Randomized bench for the dot-product engine with a queue-based scoreboard.
// Stimulus loads vectors and starts runs, pushing the expected stored byte; a monitor pops on each done.
// The monitor owns read_addr and keeps its own picture of the result ring.
module tb_top_level_system;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       system_start = 1'b0;
   logic       write_en = 1'b0;
   logic       read_en = 1'b0;
   logic [4:0] write_addr = '0;
   logic [7:0] data_a = '0;
   logic [7:0] data_b = '0;
   logic [3:0] read_addr = '0;
   logic       system_busy;
   logic       system_done;
   logic [7:0] result_out;
   logic [2:0] processing_stage;
   logic [2:0] vector_count;
   logic [2:0] result_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_q [$];
   int         model_a [32];
   int         model_b [32];
   logic [7:0] ref_res [8];
   logic [2:0] ref_cnt;

   top_level_system dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .system_start     (system_start),
      .system_busy      (system_busy),
      .system_done      (system_done),
      .write_en         (write_en),
      .write_addr       (write_addr),
      .data_a           (data_a),
      .data_b           (data_b),
      .read_en          (read_en),
      .read_addr        (read_addr),
      .result_out       (result_out),
      .processing_stage (processing_stage),
      .vector_count     (vector_count),
      .result_count     (result_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One dot-product run; entered and left just after a falling edge.
   task automatic run(input int a[4], input int b[4], input bit do_write,
                      input bit same_cycle, input bit noise);
      int cycles;
      int sum;
      if (do_write) begin
         write_en   = 1'b1;
         write_addr = 5'($urandom_range(4, 31));
         data_a     = 8'($urandom);
         data_b     = 8'($urandom);
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            write_addr = 5'(i);
            data_a     = 8'(a[i]);
            data_b     = 8'(b[i]);
            model_a[i] = a[i];
            model_b[i] = b[i];
            if (same_cycle && i == 3) system_start = 1'b1;
            @(negedge clk);
         end
         write_en = 1'b0;
      end
      sum = 0;
      for (int i = 0; i < 4; i++) sum += model_a[i] * model_b[i];
      exp_q.push_back(8'(sum % 256));
      if (!(do_write && same_cycle)) begin
         system_start = 1'b1;
         @(negedge clk);
      end
      system_start = 1'b0;
      cycles = 1;
      while (!system_done && cycles < 20) begin
         if (noise && cycles == 3) begin
            check("busy_mid_run", system_busy, 1);
            write_en     = 1'b1;
            write_addr   = 5'($urandom_range(0, 3));
            data_a       = 8'($urandom);
            data_b       = 8'($urandom);
            system_start = 1'b1;
         end else begin
            write_en     = 1'b0;
            system_start = 1'b0;
         end
         @(negedge clk);
         cycles++;
      end
      write_en     = 1'b0;
      system_start = 1'b0;
      check("done_latency", cycles, 7);
      @(negedge clk);
      check("idle_stage_after_done", processing_stage, 0);
      check("idle_busy_after_done", system_busy, 0);
   endtask

   // Stimulus
   initial begin
      int va[4];
      int vb[4];
      int saw;
      for (int i = 0; i < 32; i++) begin
         model_a[i] = 0;
         model_b[i] = 0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("reset_stage", processing_stage, 0);
      check("reset_busy", system_busy, 0);
      check("reset_done", system_done, 0);
      check("reset_result_count", result_count, 0);
      check("reset_vector_count", vector_count, 0);
      check("reset_result_out", result_out, 0);

      va = '{1, 2, 3, 4};     vb = '{1, 1, 1, 1};     run(va, vb, 1, 0, 0);
      va = '{2, 4, 6, 8};     vb = '{1, 2, 3, 4};     run(va, vb, 1, 1, 0);
      va = '{0, 5, 0, 3};     vb = '{2, 0, 4, 1};     run(va, vb, 1, 0, 1);
      va = '{255, 255, 255, 255}; vb = '{255, 255, 255, 255}; run(va, vb, 1, 0, 1);
      run(va, vb, 0, 0, 1);
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 4; i++) begin
            va[i] = $urandom_range(0, 255);
            vb[i] = $urandom_range(0, 255);
         end
         run(va, vb, 1, (r % 2) == 1, (r % 3) == 0);
      end

      // Abort a run in the middle of the multiply phase.
      system_start = 1'b1;
      @(negedge clk);
      system_start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         model_a[i] = 0;
         model_b[i] = 0;
      end
      check("abort_stage", processing_stage, 0);
      check("abort_busy", system_busy, 0);
      check("abort_result_count", result_count, 0);
      saw = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (system_done) saw++;
      end
      check("abort_no_done", saw, 0);

      run(va, vb, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         va[i] = $urandom_range(0, 255);
         vb[i] = $urandom_range(0, 255);
      end
      run(va, vb, 1, 0, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Monitor: pops an expectation on every done and reads the result ring back.
   initial begin
      logic [7:0] e;
      logic       prev_done;
      int         ra;
      prev_done = 1'b0;
      ref_cnt   = '0;
      for (int i = 0; i < 8; i++) ref_res[i] = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ref_cnt   = '0;
            prev_done = 1'b0;
            for (int i = 0; i < 8; i++) ref_res[i] = '0;
         end else if (system_done) begin
            check("done_single_cycle", prev_done, 0);
            check("done_stage", processing_stage, 4);
            check("done_busy", system_busy, 1);
            if (exp_q.size() == 0) begin
               check("unexpected_done", 0, 1);
            end else begin
               e = exp_q.pop_front();
               ref_res[ref_cnt] = e;
               ref_cnt = ref_cnt + 3'd1;
               check("result_count", result_count, ref_cnt);
               read_addr = {1'b0, 3'(ref_cnt - 3'd1)};
               #1 check("result_new_slot", result_out, e);
               ra = $urandom_range(0, 7);
               read_addr = 4'(ra);
               #1 check("result_other_slot", result_out, ref_res[ra]);
               read_addr = 4'(8 + $urandom_range(0, 7));
               #1 check("result_out_of_range", result_out, 0);
            end
            prev_done = 1'b1;
         end else begin
            prev_done = 1'b0;
         end
      end
   end

endmodule
